agc_timer_sequencer: RTL and testbench

Host-side controller for the AGC timer (`a2_timer`) control inputs. It accepts one command at a time over a valid/ready handshake and drives the timer's start, restart, standby, alarm and monitor-stop inputs with exact pulse widths. It observes `T12`, `GOJAM` and `STOP` to confirm completion of each command. It sits between the monitor/debug host logic and `a2_timer`, and runs on the `SIM_CLK` fabric clock.

---
 rtl/agc_timer_sequencer_if.sv | 12 +
 rtl/agc_timer_sequencer.sv | 147 ++++++++++++++
 tb/tb_agc_timer_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/agc_timer_sequencer_if.sv
// agc_timer_sequencer_if: command handshake and completion status between host and timer sequencer
interface agc_timer_sequencer_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [7:0] CMD_ARG;
  logic       DONE;
  logic       ERR;
  logic       BUSY;
  modport master (output CMD_VALID, CMD_OP, CMD_ARG, input CMD_READY, DONE, ERR, BUSY);
  modport slave  (input CMD_VALID, CMD_OP, CMD_ARG, output CMD_READY, DONE, ERR, BUSY);
endinterface

// File: rtl/agc_timer_sequencer.sv
// agc_timer_sequencer: drives a2_timer control inputs with exact pulse widths and confirms completion
module agc_timer_sequencer #(
  parameter int PULSE_LEN = 8,
  parameter int TIMEOUT   = 4000
) (
  input  logic                        SIM_CLK,
  input  logic                        RESET_,
  agc_timer_sequencer_if.slave        cmd,
  input  logic                        T12,
  input  logic                        GOJAM,
  input  logic                        STOP,
  output logic                        SBY,
  output logic                        ALGA,
  output logic                        MSTRTP,
  output logic                        STRT1,
  output logic                        STRT2,
  output logic                        GOJ1,
  output logic                        MSTP
);
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_DONE} state_t;
  localparam logic [2:0] OP_POWERON = 3'd1, OP_RESTART = 3'd2, OP_STANDBY = 3'd3,
                         OP_HALT = 3'd4, OP_RUN = 3'd5, OP_STEP = 3'd6, OP_ALARM = 3'd7;
  localparam logic [7:0]  PL_M1 = 8'(PULSE_LEN - 1);
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [8:0]  scnt_q, scnt_d;
  logic        err_q, err_d, sby_l_q, sby_l_d, mstp_l_q, mstp_l_d, t12_q;
  logic        ready_q, ready_d, busy_q, busy_d, done_q, done_d, erro_q, erro_d;
  logic        sby_q, sby_d, alga_q, alga_d, mstrtp_q, mstrtp_d, strt_q, strt_d;
  logic        goj1_q, goj1_d, mstp_q, mstp_d;
  logic        acc, cond;
  assign acc  = cmd.CMD_VALID & ready_q;
  assign cond = op_q == OP_HALT ? STOP : op_q == OP_STEP ? (T12 & ~t12_q) : ~GOJAM;
  always_ff @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      pcnt_q   <= '0;
      wcnt_q   <= '0;
      scnt_q   <= '0;
      err_q    <= 1'b0;
      sby_l_q  <= 1'b0;
      mstp_l_q <= 1'b0;
      t12_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pcnt_q   <= pcnt_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
      err_q    <= err_d;
      sby_l_q  <= sby_l_d;
      mstp_l_q <= mstp_l_d;
      t12_q    <= T12;
    end
  end
  // an accepted step count of 0 encodes 256 steps
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pcnt_d   = '0;
    wcnt_d   = '0;
    scnt_d   = scnt_q;
    err_d    = err_q;
    sby_l_d  = sby_l_q;
    mstp_l_d = mstp_l_q;
    case (state_q)
      S_IDLE: if (acc) begin
        op_d   = cmd.CMD_OP;
        err_d  = 1'b0;
        scnt_d = {cmd.CMD_ARG == 8'd0, cmd.CMD_ARG};
        case (cmd.CMD_OP)
          OP_POWERON, OP_RESTART, OP_ALARM: state_d = S_PULSE;
          OP_STANDBY: begin sby_l_d = cmd.CMD_ARG[0]; state_d = S_DONE; end
          OP_HALT:    begin mstp_l_d = 1'b1; state_d = S_WAIT; end
          OP_RUN:     begin mstp_l_d = 1'b0; state_d = S_DONE; end
          OP_STEP:    begin state_d = mstp_l_q ? S_PULSE : S_DONE; err_d = ~mstp_l_q; end
          default:    state_d = S_DONE;
        endcase
      end
      S_PULSE: begin
        state_d = pcnt_q != PL_M1 ? S_PULSE : op_q == OP_ALARM ? S_DONE : S_WAIT;
        pcnt_d  = pcnt_q != PL_M1 ? pcnt_q + 8'd1 : 8'd0;
      end
      S_WAIT: if (cond) begin
        state_d = (op_q == OP_STEP && scnt_q != 9'd1) ? S_PULSE : S_DONE;
        scnt_d  = scnt_q - 9'd1;
      end else if (wcnt_q == TO_M1) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else wcnt_d = wcnt_q + 16'd1;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs follow the state one edge later so every control rises the cycle after accept
  always_comb begin
    ready_d  = state_q == S_IDLE && !acc;
    busy_d   = !ready_d;
    done_d   = state_q == S_DONE;
    erro_d   = done_d & err_q;
    strt_d   = state_q == S_PULSE && op_q == OP_POWERON;
    goj1_d   = state_q == S_PULSE && op_q == OP_RESTART;
    mstrtp_d = state_q == S_PULSE && op_q == OP_STEP;
    alga_d   = state_q == S_PULSE && op_q == OP_ALARM;
    sby_d    = sby_l_q;
    mstp_d   = mstp_l_q;
  end
  always_ff @(posedge SIM_CLK or negedge RESET_) begin
    if (!RESET_) begin
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
      strt_q   <= 1'b0;
      goj1_q   <= 1'b0;
      mstrtp_q <= 1'b0;
      alga_q   <= 1'b0;
      sby_q    <= 1'b0;
      mstp_q   <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
      strt_q   <= strt_d;
      goj1_q   <= goj1_d;
      mstrtp_q <= mstrtp_d;
      alga_q   <= alga_d;
      sby_q    <= sby_d;
      mstp_q   <= mstp_d;
    end
  end
  assign cmd.CMD_READY = ready_q;
  assign cmd.BUSY      = busy_q;
  assign cmd.DONE      = done_q;
  assign cmd.ERR       = erro_q;
  assign STRT1         = strt_q;
  assign STRT2         = strt_q;
  assign GOJ1          = goj1_q;
  assign MSTRTP        = mstrtp_q;
  assign ALGA          = alga_q;
  assign SBY           = sby_q;
  assign MSTP          = mstp_q;
endmodule

// File: tb/tb_agc_timer_sequencer.sv
// tb_agc_timer_sequencer: directed checks of command timing, pulse widths, timeouts and abort
module tb_agc_timer_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, t12 = 1'b0, gojam = 1'b1, stop = 1'b0, t12_en = 1'b0;
  logic sby, alga, mstrtp, strt1, strt2, goj1, mstp, prev, got_done;
  int checks = 0, errors = 0, w1, w2, k, pulses, run, ndone;
  agc_timer_sequencer_if cmd();
  agc_timer_sequencer #(.PULSE_LEN(8), .TIMEOUT(100)) dut (
    .SIM_CLK(clk), .RESET_(rst_n), .cmd(cmd), .T12(t12), .GOJAM(gojam), .STOP(stop),
    .SBY(sby), .ALGA(alga), .MSTRTP(mstrtp), .STRT1(strt1), .STRT2(strt2), .GOJ1(goj1), .MSTP(mstp)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    int n = 0;
    while (!cmd.CMD_READY && n < 50) begin @(negedge clk); n++; end
    check("send_ready", cmd.CMD_READY, 1);
    cmd.CMD_VALID = 1'b1;
    cmd.CMD_OP    = op;
    cmd.CMD_ARG   = arg;
    @(negedge clk);
    cmd.CMD_VALID = 1'b0;
    cmd.CMD_OP    = 3'd7;
    cmd.CMD_ARG   = 8'hff;
  endtask
  // T12 is a one-cycle pulse every 24 cycles while enabled
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      if (t12_en) begin c++; t12 = (c % 24 == 0); end
      else begin c = 0; t12 = 1'b0; end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got 0 expected 1");
    $fatal(1, "watchdog");
  end
  initial begin
    cmd.CMD_VALID = 1'b0;
    cmd.CMD_OP    = 3'd0;
    cmd.CMD_ARG   = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd.CMD_READY, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", cmd.CMD_READY, 1);
    check("idle_busy", cmd.BUSY, 0);
    check("idle_done", cmd.DONE, 0);
    check("idle_ctl", {sby, alga, mstrtp, strt1, strt2, goj1, mstp}, 0);
    send(3'd0, 8'd0);
    check("nop_ready", cmd.CMD_READY, 0);
    check("nop_busy", cmd.BUSY, 1);
    check("nop_early", cmd.DONE, 0);
    @(negedge clk);
    check("nop_done", cmd.DONE, 1);
    check("nop_err", cmd.ERR, 0);
    @(negedge clk);
    check("nop_done_end", cmd.DONE, 0);
    check("nop_ready_back", cmd.CMD_READY, 1);
    send(3'd3, 8'd1);
    @(negedge clk);
    check("sby_on", sby, 1);
    check("sby_done", cmd.DONE, 1);
    send(3'd3, 8'd2);
    @(negedge clk);
    check("sby_off", sby, 0);
    check("sby_done2", cmd.DONE, 1);
    gojam = 1'b1;
    send(3'd1, 8'd0);
    w1 = 0;
    w2 = 0;
    repeat (12) begin @(negedge clk); w1 += int'(strt1); w2 += int'(strt2); end
    check("pon_strt1", w1, 8);
    check("pon_strt2", w2, 8);
    repeat (16) @(negedge clk);
    check("pon_wait", cmd.DONE, 0);
    gojam = 1'b0;
    @(negedge clk);
    check("pon_early", cmd.DONE, 0);
    @(negedge clk);
    check("pon_done", cmd.DONE, 1);
    check("pon_err", cmd.ERR, 0);
    send(3'd7, 8'd0);
    w1 = 0;
    repeat (8) begin @(negedge clk); w1 += int'(alga); end
    check("alga_width", w1, 8);
    check("alga_early", cmd.DONE, 0);
    @(negedge clk);
    check("alga_done", cmd.DONE, 1);
    check("alga_low", alga, 0);
    send(3'd5, 8'd0);
    @(negedge clk);
    check("run_done", cmd.DONE, 1);
    check("run_mstp", mstp, 0);
    send(3'd6, 8'd5);
    check("bad_step_mstrtp", mstrtp, 0);
    @(negedge clk);
    check("bad_step_done", cmd.DONE, 1);
    check("bad_step_err", cmd.ERR, 1);
    check("bad_step_mstrtp2", mstrtp, 0);
    stop = 1'b0;
    send(3'd4, 8'd0);
    @(negedge clk);
    check("halt_mstp", mstp, 1);
    check("halt_wait", cmd.DONE, 0);
    stop = 1'b1;
    @(negedge clk);
    check("halt_early", cmd.DONE, 0);
    @(negedge clk);
    check("halt_done", cmd.DONE, 1);
    check("halt_err", cmd.ERR, 0);
    t12_en = 1'b1;
    send(3'd6, 8'd3);
    pulses = 0;
    run = 0;
    prev = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      @(negedge clk);
      if (mstrtp) run++;
      else if (prev) begin check("step_width", run, 8); run = 0; pulses++; end
      prev = mstrtp;
      if (cmd.DONE) begin got_done = 1'b1; check("step_err", cmd.ERR, 0); end
    end
    t12_en = 1'b0;
    check("step_done", got_done, 1);
    check("step_pulses", pulses, 3);
    check("step_mstp", mstp, 1);
    gojam = 1'b1;
    send(3'd2, 8'd0);
    w1 = 0;
    repeat (8) begin @(negedge clk); w1 += int'(goj1); end
    check("rs_goj1", w1, 8);
    k = 0;
    w2 = 0;
    do begin @(negedge clk); k++; w2 += int'(goj1); end while (!cmd.DONE && k < 300);
    check("rs_timeout", k, 101);
    check("rs_err", cmd.ERR, 1);
    check("rs_goj1_low", w2, 0);
    send(3'd4, 8'd0);
    t12_en = 1'b1;
    send(3'd6, 8'd0);
    pulses = 0;
    prev = 1'b0;
    ndone = 0;
    for (int i = 0; i < 400 && pulses < 6; i++) begin
      @(negedge clk);
      if (mstrtp && !prev) pulses++;
      prev = mstrtp;
      ndone += int'(cmd.DONE);
    end
    check("abort_reached", pulses, 6);
    check("abort_mstrtp_pre", mstrtp, 1);
    rst_n = 1'b0;
    #1;
    check("abort_mstrtp", mstrtp, 0);
    check("abort_mstp", mstp, 0);
    @(negedge clk);
    ndone += int'(cmd.DONE);
    rst_n = 1'b1;
    t12_en = 1'b0;
    @(negedge clk);
    ndone += int'(cmd.DONE);
    check("abort_no_done", ndone, 0);
    check("abort_ready", cmd.CMD_READY, 1);
    check("abort_busy", cmd.BUSY, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
